// File: rtl/ctr_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ctr_seq_ctrl
//  Purpose  : Sequencing controller for a synchronous up-counter. Launches,
//             pauses, resumes and aborts a count run from 0 to a latched
//             limit, in one-shot or periodic (auto-restart) mode. Reports
//             busy, paused, a one-cycle done pulse and a period tally.
//  Options  : PRESCALE_EN - when defined, counting advances only on a tick
//             produced every PRESC cycles; otherwise every cycle is a tick.
//  Revision : 1.0 - initial release
// ============================================================================
module ctr_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int PRESC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             paused,
    output logic             done,
    output logic [3:0]       wraps
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] lim_q,   lim_d;
    logic             mode_q,  mode_d;
    logic [3:0]       wraps_q, wraps_d;
    logic             done_q,  done_d;
    logic             busy_q,  busy_d;
    logic             paused_q, paused_d;
    logic             w_tick;

`ifdef PRESCALE_EN
    localparam int              PW        = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(PRESC - 1);

    logic [PW-1:0] presc_q, presc_d;

    // Tick fires on the last cycle of each prescaler period
    always_comb begin
        w_tick = (presc_q == PRESC_MAX);
    end

    // Prescaler phase register; cleared by reset, next value set by the FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    // No prescaler: every cycle is a tick (PRESC is always >= 1)
    assign w_tick = (PRESC >= 1);
`endif

    // Next-state and next-output logic for the sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lim_d   = lim_q;
        mode_d  = mode_q;
        wraps_d = wraps_q;
        done_d  = 1'b0;
`ifdef PRESCALE_EN
        presc_d = presc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // stop blocks a launch; q simply holds its last value
                if (start && !stop) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    lim_d   = limit;
                    mode_d  = mode;
                    wraps_d = 4'd0;
`ifdef PRESCALE_EN
                    presc_d = '0;
`endif
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_PAUSE;
                end else begin
`ifdef PRESCALE_EN
                    presc_d = w_tick ? '0 : presc_q + 1'b1;
`endif
                    // Compare before increment so the full range never overflows
                    if (w_tick) begin
                        if (cnt_q == lim_q) begin
                            done_d = 1'b1;
                            if (mode_q) begin
                                cnt_d   = '0;
                                wraps_d = wraps_q + 4'd1;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            ST_PAUSE: begin
                // Abort wins over resume; prescaler phase stays frozen
                if (stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (start) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d   = (state_d != ST_IDLE);
        paused_d = (state_d == ST_PAUSE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            lim_q    <= '0;
            mode_q   <= 1'b0;
            wraps_q  <= 4'd0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lim_q    <= lim_d;
            mode_q   <= mode_d;
            wraps_q  <= wraps_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            paused_q <= paused_d;
        end
    end

    assign q      = cnt_q;
    assign busy   = busy_q;
    assign paused = paused_q;
    assign done   = done_q;
    assign wraps  = wraps_q;

endmodule
`default_nettype wire
